// File: rtl/spike_rate_encoder_if.sv
// Host-facing load/start controls and the spike stream of the rate encoder.
// The master side drives loads and starts; the slave side is the encoder.
interface spike_rate_encoder_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int WIDTH_P      = 8,
  parameter int NUM_STEPS    = 16
) ();
  localparam int STEP_W = $clog2(NUM_STEPS);

  logic                    load_valid_i;
  logic [WIDTH_P-1:0]      load_data_i;
  logic                    load_ready_o;
  logic                    start_i;
  logic                    busy_o;
  logic [NUM_CHANNELS-1:0] spike_o;
  logic                    spike_valid_o;
  logic [STEP_W-1:0]       step_o;
  logic                    done_o;

  modport slave (
    input  load_valid_i, load_data_i, start_i,
    output load_ready_o, busy_o, spike_o, spike_valid_o, step_o, done_o
  );

  modport master (
    output load_valid_i, load_data_i, start_i,
    input  load_ready_o, busy_o, spike_o, spike_valid_o, step_o, done_o
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Bernoulli rate encoder: compares per-channel intensities against rotations of a
// 16-bit Fibonacci LFSR to emit NUM_STEPS spike vectors per presentation window.
//
// state | meaning
// IDLE  | accept intensity loads, wait for start
// RUN   | emit one registered spike vector per cycle
module spike_rate_encoder #(
  parameter int          NUM_CHANNELS = 8,
  parameter int          WIDTH_P      = 8,
  parameter int          NUM_STEPS    = 16,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spike_rate_encoder_if.slave bus
);
  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam int PTR_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [WIDTH_P-1:0] MAX_I = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  r_state;
  logic [WIDTH_P-1:0]      r_intensity [NUM_CHANNELS];
  logic [PTR_W-1:0]        r_ptr;
  logic [15:0]             r_lfsr;
  logic [STEP_W-1:0]       r_step;
  logic [NUM_CHANNELS-1:0] r_spike;
  logic                    r_spike_valid;
  logic [STEP_W-1:0]       r_step_out;
  logic                    r_done;

  logic [31:0]             w_lfsr2;
  logic [31:0]             w_rot;
  logic                    w_fb;
  logic [NUM_CHANNELS-1:0] w_spike;

  assign w_lfsr2 = {r_lfsr, r_lfsr};
  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Each channel draws its sample from a different rotation of the same LFSR word.
  always_comb begin
    w_spike = '0;
    w_rot   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_rot      = w_lfsr2 >> (c % 16);
      w_spike[c] = (r_intensity[c] == MAX_I) || (w_rot[WIDTH_P-1:0] < r_intensity[c]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      for (int c = 0; c < NUM_CHANNELS; c++) r_intensity[c] <= '0;
      r_ptr         <= '0;
      r_lfsr        <= SEED;
      r_step        <= '0;
      r_spike       <= '0;
      r_spike_valid <= 1'b0;
      r_step_out    <= '0;
      r_done        <= 1'b0;
    end else begin
      // The cycle after the final valid step is the first one seen in IDLE with valid high.
      r_done <= (r_state == IDLE) && r_spike_valid;
      case (r_state)
        IDLE: begin
          r_spike       <= '0;
          r_spike_valid <= 1'b0;
          r_step_out    <= '0;
          if (bus.load_valid_i) begin
            r_intensity[r_ptr] <= bus.load_data_i;
            if (r_ptr == PTR_W'(NUM_CHANNELS - 1)) r_ptr <= '0;
            else                                    r_ptr <= r_ptr + 1'b1;
          end
          if (bus.start_i) begin
            r_state <= RUN;
            r_lfsr  <= SEED;
            r_ptr   <= '0;
            r_step  <= '0;
          end
        end
        RUN: begin
          r_spike       <= w_spike;
          r_spike_valid <= 1'b1;
          r_step_out    <= r_step;
          r_step        <= r_step + 1'b1;
          r_lfsr        <= {r_lfsr[14:0], w_fb};
          if (r_step == STEP_W'(NUM_STEPS - 1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready_o  = (r_state == IDLE);
  assign bus.busy_o        = (r_state == RUN);
  assign bus.spike_o       = r_spike;
  assign bus.spike_valid_o = r_spike_valid;
  assign bus.step_o        = r_step_out;
  assign bus.done_o        = r_done;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: table vectors, randomized windows
// against an arithmetic reference model, and reset/wrap/ignore corner sequences.
module tb_spike_rate_encoder;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spike_rate_encoder_if #(.NUM_CHANNELS(8), .WIDTH_P(8), .NUM_STEPS(16))  bus1 ();
  spike_rate_encoder_if #(.NUM_CHANNELS(8), .WIDTH_P(8), .NUM_STEPS(256)) bus2 ();

  spike_rate_encoder #(.NUM_CHANNELS(8), .WIDTH_P(8), .NUM_STEPS(16), .SEED(SEED)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1));
  spike_rate_encoder #(.NUM_CHANNELS(8), .WIDTH_P(8), .NUM_STEPS(256), .SEED(SEED)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Expected spike vector: sample r_c = ((lfsr:lfsr) >> c) mod 256 compared with intensity.
  function automatic logic [7:0] model_spikes(input logic [15:0] l, input logic [63:0] intens);
    logic [31:0] d;
    logic [7:0]  s;
    d = {l, l};
    s = '0;
    for (int c = 0; c < 8; c++) begin
      int r, iv;
      r  = int'((d >> c) & 32'hFF);
      iv = int'(intens[c*8 +: 8]);
      s[c] = (iv == 255) || (r < iv);
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] intens;
    logic [7:0]  exp_spike;
  } vec_t;

  vec_t vecs[5];

  task automatic load_all(input logic [63:0] v);
    for (int c = 0; c < 8; c++) begin
      bus1.load_valid_i = 1'b1;
      bus1.load_data_i  = v[c*8 +: 8];
      @(negedge clk);
    end
    bus1.load_valid_i = 1'b0;
  endtask

  task automatic run_window(input logic [63:0] intens, input bit poke, input bit const_chk,
                            input logic [7:0] cexp, input bit load_with_start,
                            input logic [7:0] ld);
    logic [15:0] l;
    bus1.start_i = 1'b1;
    if (load_with_start) begin
      bus1.load_valid_i = 1'b1;
      bus1.load_data_i  = ld;
    end
    @(negedge clk);
    bus1.start_i      = 1'b0;
    bus1.load_valid_i = 1'b0;
    chk("busy_after_start", bus1.busy_o, 1);
    chk("valid_one_edge_after_start", bus1.spike_valid_o, 0);
    chk("load_ready_in_run", bus1.load_ready_o, 0);
    l = SEED;
    for (int k = 0; k < 16; k++) begin
      if (poke && k >= 2 && k <= 5) begin
        bus1.load_valid_i = 1'b1;
        bus1.load_data_i  = 8'hFF;
        bus1.start_i      = 1'b1;
      end else begin
        bus1.load_valid_i = 1'b0;
        bus1.start_i      = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("valid_step%0d", k), bus1.spike_valid_o, 1);
      chk($sformatf("step_index%0d", k), bus1.step_o, k);
      chk($sformatf("spike_model_step%0d", k), bus1.spike_o, model_spikes(l, intens));
      if (const_chk) chk($sformatf("spike_table_step%0d", k), bus1.spike_o, cexp);
      if (k < 15) chk("done_low_in_run", bus1.done_o, 0);
      l = lfsr_next(l);
    end
    bus1.load_valid_i = 1'b0;
    bus1.start_i      = 1'b0;
    @(negedge clk);
    chk("valid_after_window", bus1.spike_valid_o, 0);
    chk("spike_after_window", bus1.spike_o, 0);
    chk("done_pulse", bus1.done_o, 1);
    chk("load_ready_after", bus1.load_ready_o, 1);
    chk("busy_after", bus1.busy_o, 0);
    @(negedge clk);
    chk("done_one_cycle", bus1.done_o, 0);
  endtask

  logic [63:0] iv;
  logic [7:0]  seq1 [256];
  logic [7:0]  seq2 [256];
  int          cnt  [8];
  bit          found;

  initial begin
    bus1.load_valid_i = 0; bus1.load_data_i = 0; bus1.start_i = 0;
    bus2.load_valid_i = 0; bus2.load_data_i = 0; bus2.start_i = 0;

    vecs[0] = '{"all_zero",   64'h0000000000000000, 8'h00};
    vecs[1] = '{"all_ff",     64'hFFFFFFFFFFFFFFFF, 8'hFF};
    vecs[2] = '{"ch0_only",   64'h00000000000000FF, 8'h01};
    vecs[3] = '{"ch7_only",   64'hFF00000000000000, 8'h80};
    vecs[4] = '{"even_chans", 64'h00FF00FF00FF00FF, 8'h55};

    repeat (2) @(negedge clk);
    chk("rst_spike", bus1.spike_o, 0);
    chk("rst_valid", bus1.spike_valid_o, 0);
    chk("rst_step", bus1.step_o, 0);
    chk("rst_done", bus1.done_o, 0);
    chk("rst_busy", bus1.busy_o, 0);
    chk("rst_load_ready", bus1.load_ready_o, 1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      load_all(vecs[i].intens);
      run_window(vecs[i].intens, 0, 1, vecs[i].exp_spike, 0, 8'h00);
    end

    // Nine loads: the ninth wraps onto channel 0; RUN-time loads/starts must be ignored.
    iv = '0;
    for (int i = 0; i < 9; i++) begin
      bus1.load_valid_i = 1'b1;
      bus1.load_data_i  = 8'(8'h11 * (i + 1));
      iv[(i % 8)*8 +: 8] = 8'(8'h11 * (i + 1));
      @(negedge clk);
    end
    bus1.load_valid_i = 1'b0;
    run_window(iv, 1, 0, 8'h00, 0, 8'h00);
    run_window(iv, 0, 0, 8'h00, 0, 8'h00);

    // Load coinciding with start lands on channel 0 and is used by that window.
    iv[7:0] = 8'hFF;
    run_window(iv, 0, 0, 8'h00, 1, 8'hFF);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        case ($urandom_range(0, 5))
          0:       iv[c*8 +: 8] = 8'h00;
          1:       iv[c*8 +: 8] = 8'hFF;
          default: iv[c*8 +: 8] = 8'($urandom_range(0, 255));
        endcase
      end
      load_all(iv);
      run_window(iv, 0, 0, 8'h00, 0, 8'h00);
    end

    load_all(64'hFFFFFFFFFFFFFFFF);
    bus1.start_i = 1'b1;
    @(negedge clk);
    bus1.start_i = 1'b0;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus1.spike_valid_o && bus1.step_o == 4'd5) found = 1;
    end
    chk("reached_step5", found, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus1.spike_valid_o, 0);
    chk("midrst_busy", bus1.busy_o, 0);
    chk("midrst_spike", bus1.spike_o, 0);
    chk("midrst_step", bus1.step_o, 0);
    chk("midrst_load_ready", bus1.load_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("no_done_after_rst", bus1.done_o, 0);
      chk("no_valid_after_rst", bus1.spike_valid_o, 0);
    end
    run_window(64'h0, 0, 1, 8'h00, 0, 8'h00);

    for (int c = 0; c < 8; c++) begin
      bus2.load_valid_i = 1'b1;
      bus2.load_data_i  = 8'h80;
      @(negedge clk);
    end
    bus2.load_valid_i = 1'b0;
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    for (int w = 0; w < 2; w++) begin
      logic [15:0] l;
      bus2.start_i = 1'b1;
      @(negedge clk);
      bus2.start_i = 1'b0;
      l = SEED;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk);
        if (!bus2.spike_valid_o || bus2.step_o != 8'(k)) begin
          chk("n256_valid_step", {bus2.spike_valid_o, 8'(bus2.step_o)}, {1'b1, 8'(k)});
        end
        if (w == 0) begin
          seq1[k] = bus2.spike_o;
          for (int c = 0; c < 8; c++) cnt[c] += int'(bus2.spike_o[c]);
        end else begin
          seq2[k] = bus2.spike_o;
        end
        l = lfsr_next(l);
      end
      @(negedge clk);
      chk("n256_done", bus2.done_o, 1);
    end
    begin
      logic [15:0] l;
      int bad_model, bad_repeat;
      l = SEED;
      bad_model = 0;
      bad_repeat = 0;
      for (int k = 0; k < 256; k++) begin
        if (seq1[k] !== model_spikes(l, {8{8'h80}})) bad_model++;
        if (seq2[k] !== seq1[k]) bad_repeat++;
        l = lfsr_next(l);
      end
      chk("n256_model_mismatches", bad_model, 0);
      chk("n256_repeat_mismatches", bad_repeat, 0);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (cnt[c] < 104 || cnt[c] > 152) begin
        errors++;
        $display("FAIL n256_count_ch%0d: got %0d expected 104..152", c, cnt[c]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
